// File: rtl/acquire_trig.sv
// Triggered ADC acquisition controller: arms on a threshold crossing, then streams
// raw samples (scope mode) or packed threshold bits (logic mode) into a capture RAM.
module acquire_trig #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              grant_acq,
  input  logic              mode,
  input  logic              trig_en,
  input  logic              trig_edge,
  input  logic [DATA_W-1:0] threshold,
  input  logic [DATA_W-1:0] adc_data,
  output logic              done_acq,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              wr_en,
  output logic              armed
);

  localparam int unsigned BCNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
  localparam logic [BCNT_W-1:0] BIT_LAST = BCNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAPTURE, S_DONE} state_t;

  state_t              state_q, state_d;
  logic                cmp_prev_q;
  logic                seed_q;
  logic                mode_q, mode_d;
  logic                trig_en_q, trig_en_d;
  logic                edge_q, edge_d;
  logic [DATA_W-1:0]   thr_q, thr_d;
  logic [DATA_W-1:0]   pack_q, pack_d;
  logic [BCNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [ADDR_W-1:0]   iss_q, iss_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic                wr_en_q, wr_en_d;
  logic                done_q, done_d;
  logic                armed_q, armed_d;

  logic [DATA_W-1:0]   thr_eff_c;
  logic                cmp_c;
  logic                trig_hit_c;
  logic                take_c;
  logic                issue_c;

  // Threshold compare; the live threshold only matters before it is latched.
  always_comb begin
    thr_eff_c  = (state_q == S_IDLE) ? threshold : thr_q;
    cmp_c      = (adc_data > thr_eff_c);
    trig_hit_c = ~seed_q & (edge_q ? (cmp_c & ~cmp_prev_q) : (~cmp_c & cmp_prev_q));
  end

  // Next-state and datapath
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    trig_en_d = trig_en_q;
    edge_d    = edge_q;
    thr_d     = thr_q;
    pack_d    = pack_q;
    bit_cnt_d = bit_cnt_q;
    iss_d     = iss_q;
    wr_data_d = wr_data_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    take_c    = 1'b0;
    issue_c   = 1'b0;

    // Address advances after each visible strobe and parks on the last word.
    if (wr_en_q && (wr_addr_q != ADDR_MAX)) begin
      wr_addr_d = wr_addr_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        wr_addr_d = '0;
        bit_cnt_d = '0;
        iss_d     = '0;
        if (grant_acq) begin
          mode_d    = mode;
          trig_en_d = trig_en;
          edge_d    = trig_edge;
          thr_d     = threshold;
          state_d   = trig_en ? S_ARMED : S_CAPTURE;
        end
      end
      S_ARMED: begin
        if (!grant_acq) begin
          state_d   = S_IDLE;
          wr_addr_d = '0;
        end else if (trig_hit_c) begin
          take_c  = 1'b1;
          state_d = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        if (!grant_acq) begin
          state_d   = S_IDLE;
          wr_addr_d = '0;
        end else begin
          take_c = 1'b1;
        end
      end
      S_DONE: begin
        if (!grant_acq) begin
          state_d   = S_IDLE;
          wr_addr_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (take_c) begin
      if (!mode_q) begin
        wr_data_d = adc_data;
        issue_c   = 1'b1;
      end else begin
        pack_d = {cmp_c, pack_q[DATA_W-1:1]};
        if (bit_cnt_q == BIT_LAST) begin
          bit_cnt_d = '0;
          wr_data_d = pack_d;
          issue_c   = 1'b1;
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
    end

    // The final issued write hands over to DONE; its strobe lands on DONE entry.
    if (issue_c) begin
      wr_en_d = 1'b1;
      if (iss_q == ADDR_MAX) begin
        state_d = S_DONE;
      end else begin
        iss_d = iss_q + 1'b1;
      end
    end

    done_d  = (state_d == S_DONE);
    armed_d = (state_d == S_ARMED);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cmp_prev_q <= 1'b0;
      seed_q     <= 1'b0;
      mode_q     <= 1'b0;
      trig_en_q  <= 1'b0;
      edge_q     <= 1'b0;
      thr_q      <= '0;
      pack_q     <= '0;
      bit_cnt_q  <= '0;
      iss_q      <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      wr_en_q    <= 1'b0;
      done_q     <= 1'b0;
      armed_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmp_prev_q <= cmp_c;
      seed_q     <= (state_q == S_IDLE);
      mode_q     <= mode_d;
      trig_en_q  <= trig_en_d;
      edge_q     <= edge_d;
      thr_q      <= thr_d;
      pack_q     <= pack_d;
      bit_cnt_q  <= bit_cnt_d;
      iss_q      <= iss_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      wr_en_q    <= wr_en_d;
      done_q     <= done_d;
      armed_q    <= armed_d;
    end
  end

  assign done_acq = done_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign wr_en    = wr_en_q;
  assign armed    = armed_q;

endmodule

// File: tb/tb_acquire_trig.sv
// Bench for acquire_trig (DATA_W=8, ADDR_W=4): vector table, directed sequences and
// randomized sessions checked against a per-session reference of expected outputs.
module tb_acquire_trig;

  localparam int DW   = 8;
  localparam int AW   = 4;
  localparam int NW   = 16;
  localparam int MAXC = 300;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          grant_acq = 1'b0;
  logic          mode = 1'b0;
  logic          trig_en = 1'b0;
  logic          trig_edge = 1'b0;
  logic [DW-1:0] threshold = '0;
  logic [DW-1:0] adc_data = '0;
  logic          done_acq;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_en;
  logic          armed;

  always #5 clk = ~clk;

  acquire_trig #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .grant_acq(grant_acq), .mode(mode), .trig_en(trig_en),
    .trig_edge(trig_edge), .threshold(threshold), .adc_data(adc_data),
    .done_acq(done_acq), .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en), .armed(armed)
  );

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0] adc_a [MAXC];
  logic       ex_en [MAXC];
  logic       ex_armed [MAXC];
  logic       ex_done [MAXC];
  logic [3:0] ex_addr [MAXC];
  logic [7:0] ex_data [MAXC];
  logic [7:0] first_data;
  int         nwrites_seen;

  typedef struct {
    logic       grant;
    logic [7:0] adc;
    logic       armed;
    logic       en;
    logic [3:0] addr;
    logic [7:0] data;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One capture session: grant sampled at edge 0, dropped at edge D.
  task automatic run_session(input logic c_mode, input logic c_trig, input logic c_edge,
                             input logic [7:0] c_thr, input int abort_at, input int hold);
    int         s, L, D, cnt;
    int         wedge [NW];
    logic [7:0] wdata [NW];
    bit         cmpv [MAXC];
    for (int k = 0; k < MAXC; k++) cmpv[k] = (adc_a[k] > c_thr);
    s = -1;
    if (!c_trig) s = 1;
    else
      for (int k = 2; k < MAXC; k++)
        if (s < 0 && (c_edge ? (cmpv[k] && !cmpv[k-1]) : (!cmpv[k] && cmpv[k-1]))) s = k;
    for (int j = 0; j < NW; j++) begin
      wedge[j] = MAXC + 10;
      wdata[j] = '0;
      if (s >= 0) begin
        if (!c_mode) begin
          if (s + j < MAXC) begin
            wedge[j] = s + j;
            wdata[j] = adc_a[s + j];
          end
        end else if (s + 8*j + 7 < MAXC) begin
          wedge[j] = s + 8*j + 7;
          for (int b = 0; b < 8; b++) wdata[j][b] = cmpv[s + 8*j + b];
        end
      end
    end
    L = wedge[NW-1];
    D = (abort_at > 0) ? abort_at : L + hold;
    if (D > MAXC - 2) D = MAXC - 2;
    for (int e = 0; e <= D + 1; e++) begin
      ex_en[e] = 1'b0; ex_armed[e] = 1'b0; ex_done[e] = 1'b0; ex_addr[e] = '0; ex_data[e] = '0;
      if (e < D) begin
        ex_armed[e] = c_trig && (s < 0 || e < s);
        cnt = 0;
        for (int j = 0; j < NW; j++) begin
          if (wedge[j] < e) cnt++;
          if (wedge[j] == e) begin
            ex_en[e]   = 1'b1;
            ex_data[e] = wdata[j];
          end
        end
        ex_addr[e] = 4'((cnt > 15) ? 15 : cnt);
        ex_done[e] = (L < MAXC) && (e >= L);
      end
    end
    nwrites_seen = 0;
    first_data   = '0;
    for (int e = 0; e <= D + 1; e++) begin
      grant_acq = (e < D);
      adc_data  = adc_a[e];
      if (e == 0) begin
        mode = c_mode; trig_en = c_trig; trig_edge = c_edge; threshold = c_thr;
      end else begin
        mode = 1'($urandom); trig_en = 1'($urandom); trig_edge = 1'($urandom);
        threshold = 8'($urandom);
      end
      tick();
      chk($sformatf("cyc%0d status{armed,done,en,addr}", e),
          32'({armed, done_acq, wr_en, wr_addr}),
          32'({ex_armed[e], ex_done[e], ex_en[e], ex_addr[e]}));
      if (ex_en[e]) chk($sformatf("cyc%0d wr_data", e), 32'(wr_data), 32'(ex_data[e]));
      if (wr_en) begin
        if (nwrites_seen == 0) first_data = wr_data;
        nwrites_seen++;
      end
    end
  endtask

  task automatic fill_random();
    for (int k = 0; k < MAXC; k++) adc_a[k] = 8'($urandom_range(0, 255));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [9];
    bit   found;
    tbl[0] = '{1'b1, 8'h10, 1'b1, 1'b0, 4'd0, 8'h00};
    tbl[1] = '{1'b1, 8'h10, 1'b1, 1'b0, 4'd0, 8'h00};
    tbl[2] = '{1'b1, 8'h10, 1'b1, 1'b0, 4'd0, 8'h00};
    tbl[3] = '{1'b1, 8'h10, 1'b1, 1'b0, 4'd0, 8'h00};
    tbl[4] = '{1'b1, 8'h10, 1'b1, 1'b0, 4'd0, 8'h00};
    tbl[5] = '{1'b1, 8'h90, 1'b0, 1'b1, 4'd0, 8'h90};
    tbl[6] = '{1'b1, 8'h91, 1'b0, 1'b1, 4'd1, 8'h91};
    tbl[7] = '{1'b1, 8'h05, 1'b0, 1'b1, 4'd2, 8'h05};
    tbl[8] = '{1'b0, 8'h05, 1'b0, 1'b0, 4'd0, 8'h00};

    // Reset state
    rst = 1'b1;
    adc_data = 8'hA5;
    tick();
    tick();
    chk("reset outputs", 32'({armed, done_acq, wr_en, wr_addr, wr_data}), 32'(0));
    rst = 1'b0;

    // Triggered scope capture, rising edge at 0x80, then abort
    mode = 1'b0; trig_en = 1'b1; trig_edge = 1'b1; threshold = 8'h80;
    for (int i = 0; i < 9; i++) begin
      grant_acq = tbl[i].grant;
      adc_data  = tbl[i].adc;
      tick();
      chk($sformatf("vec%0d armed", i), 32'(armed), 32'(tbl[i].armed));
      chk($sformatf("vec%0d wr_en", i), 32'(wr_en), 32'(tbl[i].en));
      chk($sformatf("vec%0d wr_addr", i), 32'(wr_addr), 32'(tbl[i].addr));
      chk($sformatf("vec%0d done", i), 32'(done_acq), 32'(0));
      if (tbl[i].en) chk($sformatf("vec%0d wr_data", i), 32'(wr_data), 32'(tbl[i].data));
    end

    // Untriggered scope ramp, full capture then hold in DONE
    adc_a[0] = 8'hFF;
    for (int k = 1; k < MAXC; k++) adc_a[k] = 8'(k - 1);
    run_session(1'b0, 1'b0, 1'b0, 8'h00, 0, 4);
    chk("ramp write count", 32'(nwrites_seen), 32'(16));
    chk("ramp first data", 32'(first_data), 32'(8'h00));

    // Logic mode, falling trigger at 0x40: first word 0x9A
    fill_random();
    adc_a[0] = 8'h50; adc_a[1] = 8'h50; adc_a[2] = 8'h50;
    adc_a[3] = 8'h10; adc_a[4] = 8'h50; adc_a[5] = 8'h10; adc_a[6] = 8'h50;
    adc_a[7] = 8'h50; adc_a[8] = 8'h10; adc_a[9] = 8'h10; adc_a[10] = 8'h50;
    run_session(1'b1, 1'b1, 1'b0, 8'h40, 0, 2);
    chk("logic first word", 32'(first_data), 32'(8'h9A));
    chk("logic write count", 32'(nwrites_seen), 32'(16));

    // Abort after five scope writes
    fill_random();
    run_session(1'b0, 1'b0, 1'b0, 8'h55, 6, 0);
    chk("abort write count", 32'(nwrites_seen), 32'(5));

    // Reset in the middle of a capture at address 7
    grant_acq = 1'b1; mode = 1'b0; trig_en = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      adc_data = 8'($urandom);
      tick();
      if (wr_en && wr_addr == 4'd7) found = 1'b1;
    end
    chk("reach addr 7 within budget", 32'(found), 32'(1));
    rst = 1'b1;
    tick();
    chk("mid-capture reset outputs", 32'({armed, done_acq, wr_en, wr_addr, wr_data}), 32'(0));
    rst = 1'b0;
    fill_random();
    run_session(1'b0, 1'b0, 1'b0, 8'h00, 0, 1);
    chk("post-reset write count", 32'(nwrites_seen), 32'(16));

    // Randomized sessions; live config inputs toggle after each grant
    for (int r = 0; r < 12; r++) begin
      logic m, t, ed;
      logic [7:0] th;
      int ab;
      fill_random();
      m  = 1'($urandom);
      t  = 1'($urandom);
      ed = 1'($urandom);
      th = 8'($urandom_range(8'h20, 8'hE0));
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 40)) : 0;
      run_session(m, t, ed, th, ab, int'($urandom_range(1, 4)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/acquire_trig.md
ACQUIRE_TRIG -- requirements
Module: acquire_trig

Interface
REQ-001 Parameter DATA_W, default 8: ADC sample width and RAM word width.
REQ-002 Parameter ADDR_W, default 10: RAM address width; capture depth is 2^ADDR_W words.
REQ-003 clk  input  1  sole clock; all logic updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 grant_acq  input  1  level request to start one capture; held high until done_acq is seen.
REQ-006 mode  input  1  capture mode: 0 = scope (raw samples), 1 = logic (thresholded bits packed into words).
REQ-007 trig_en  input  1  1 = wait for a trigger before capture; 0 = capture immediately.
REQ-008 trig_edge  input  1  trigger polarity: 1 = rising crossing, 0 = falling crossing.
REQ-009 threshold  input  DATA_W  comparison level.
REQ-010 adc_data  input  DATA_W  sample, valid every cycle.
REQ-011 done_acq  output  1  capture complete.
REQ-012 wr_addr  output  ADDR_W  RAM write address.
REQ-013 wr_data  output  DATA_W  RAM write data.
REQ-014 wr_en  output  1  RAM write strobe.
REQ-015 armed  output  1  high while in state ARMED.

Function
REQ-016 States SHALL be IDLE, ARMED, CAPTURE and DONE, encoded in one state register.
REQ-017 Compare bit SHALL be cmp = (adc_data > threshold), unsigned, strictly greater; cmp_d SHALL be cmp registered every cycle in every state.
REQ-018 Config latch: in the IDLE cycle where grant_acq=1, mode, trig_en, trig_edge and threshold SHALL be latched; the latched copies SHALL govern the whole capture, so later changes have no effect.
REQ-019 IDLE->ARMED when grant_acq=1 and trig_en=1; IDLE->CAPTURE when grant_acq=1 and trig_en=0.
REQ-020 Trigger condition:
- rising = cmp & ~cmp_d; falling = ~cmp & cmp_d.
- Evaluation SHALL start in the second ARMED cycle; the first ARMED cycle SHALL only seed cmp_d.
- ARMED->CAPTURE on the edge where the selected edge is true.
REQ-021 The trigger sample SHALL be the first sample captured; capture SHALL begin in that same cycle.
REQ-022 grant_acq falling to 0 in ARMED or CAPTURE SHALL abort to IDLE: no further writes, done_acq stays 0, wr_addr cleared to 0.
REQ-023 Scope mode:
- Each CAPTURE cycle SHALL register adc_data into wr_data and assert wr_en in the following cycle.
- One write per cycle, no gaps.
REQ-024 Logic mode:
- Each CAPTURE cycle SHALL shift cmp into a DATA_W-bit packer; the first captured bit lands in bit 0, bit k in bit k.
- After DATA_W bits, the packed word SHALL be presented on wr_data with wr_en=1 for one cycle.
- The bit counter SHALL wrap to 0 with no lost sample.
REQ-025 wr_addr SHALL start at 0 for each capture and increment by 1 after each write strobe.
REQ-026 When the write at address 2^ADDR_W-1 issues, the FSM SHALL enter DONE in the next cycle. The address SHALL NOT wrap during a capture, and nothing SHALL be written after that final write.
REQ-027 Writes per capture SHALL be exactly 2^ADDR_W in both modes.
REQ-028 done_acq SHALL be 1 only in DONE, held until grant_acq=0; then DONE->IDLE with wr_addr cleared to 0.
REQ-029 wr_en SHALL be 0 in IDLE, ARMED and DONE, except for the single pipelined write still completing on entry to DONE.
REQ-030 Reaching the last write, a trigger or a grant change SHALL NOT cause duplicate writes; a new grant_acq in DONE SHALL be ignored until it has dropped to 0.

Reset
REQ-031 rst=1 SHALL override all other inputs at the clock edge, including mid-capture.
REQ-032 Reset values: state IDLE, wr_en=0, done_acq=0, armed=0, wr_addr=0, wr_data=0, packer=0, bit counter=0, cmp_d=0, latched configuration=0.
REQ-033 First legal grant SHALL be sampled on the first edge with rst=0.

Verification
REQ-034 Scope, untriggered, ADDR_W=4: grant with adc_data ramping 0,1,2..: 16 consecutive wr_en pulses at addr 0..15, data 0..15 (one cycle latency); done_acq next cycle; hold until grant drops.
REQ-035 Scope, trig_en=1, rising, threshold=0x80: adc 0x10 x5, then 0x90: armed high until the 0x90 edge; first write data 0x90 at addr 0.
REQ-036 Logic, DATA_W=8, falling trigger, threshold=0x40: bits after trigger 0,1,0,1,1,0,0,1: first word 0x9A (bit0 = trigger sample = 0) at addr 0.
REQ-037 Abort: drop grant_acq after 5 scope writes: no 6th write, done_acq=0, wr_addr=0, state IDLE.
REQ-038 Reset mid-capture at addr 7: the next cycle shows all outputs at reset values; a fresh grant restarts at addr 0.
REQ-039 Config change mid-capture (mode toggled after grant): behaviour follows the latched mode and all 2^ADDR_W writes complete.
